// File: rtl/led_fade_pwm.sv
// led_fade_pwm: per-channel fade/PWM generator feeding SB_RGBA_DRV; define LED_FADE_BREATHE_EN to make green breathe on its own
module led_fade_pwm #(
    parameter int PWM_BITS  = 8,
    parameter int STEP_LOG2 = 14,
    parameter int MAX_DUTY  = 2**PWM_BITS-1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_blue,
    input  logic req_red,
    input  logic req_green,
    output logic blue_pwm,
    output logic red_pwm,
    output logic green_pwm,
    output logic busy
);
    localparam logic [1:0] OFF     = 2'd0;
    localparam logic [1:0] RISING  = 2'd1;
    localparam logic [1:0] ON      = 2'd2;
    localparam logic [1:0] FALLING = 2'd3;
    localparam logic [PWM_BITS-1:0] MAX_L = PWM_BITS'(MAX_DUTY);
    localparam logic [PWM_BITS-1:0] TOP   = '1;
`ifdef LED_FADE_BREATHE_EN
    localparam logic [2:0] BREATHE = 3'b100;
`else
    localparam logic [2:0] BREATHE = 3'b000;
`endif

    logic [2:0]           req_m, req_s;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic [STEP_LOG2-1:0] presc;
    logic                 tick;
    logic [2:0]           pwm_q, active;

    // two-flop synchronizer for the asynchronous request levels
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            req_m <= '0;
            req_s <= '0;
        end else begin
            req_m <= {req_green, req_red, req_blue};
            req_s <= req_m;
        end

    // free-running PWM counter and fade-rate prescaler
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pwm_cnt <= '0;
            presc   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            presc   <= presc + 1'b1;
        end

    assign tick = &presc;

    for (genvar c = 0; c < 3; c++) begin : g_ch
        localparam bit BR = BREATHE[c];
        logic [1:0]          state, state_nxt;
        logic [PWM_BITS-1:0] level, duty;
        logic                pwm;

        // breathing channel bounces between the rails; others follow their request
        always_comb
            if (BR)
                state_nxt = (state == RISING && level == MAX_L) ? FALLING :
                            (state == FALLING && level == '0)   ? RISING  : state;
            else if (!req_s[c])
                state_nxt = (state == OFF || (state == FALLING && level == '0)) ? OFF : FALLING;
            else
                state_nxt = (state == ON || (state == RISING && level == MAX_L)) ? ON : RISING;

        // FSM, saturating level ramp, period-aligned shadow duty and registered PWM bit
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                state <= BR ? RISING : OFF;
                level <= '0;
                duty  <= '0;
                pwm   <= 1'b0;
            end else begin
                state <= state_nxt;
                if (tick && state == RISING && level < MAX_L)
                    level <= level + 1'b1;
                else if (tick && state == FALLING && level != '0)
                    level <= level - 1'b1;
                if (pwm_cnt == TOP)
                    duty <= level;
                pwm <= pwm_cnt < duty;
            end

        assign pwm_q[c]  = pwm;
        assign active[c] = !BR && (state == RISING || state == FALLING);
    end

    assign {green_pwm, red_pwm, blue_pwm} = pwm_q;
    assign busy = |active;
endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: scoreboard bench for led_fade_pwm with 4-bit PWM and a tick every 4 clocks
module tb_led_fade_pwm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_blue = 1'b0, req_red = 1'b0, req_green = 1'b0;
    logic blue_pwm, red_pwm, green_pwm, busy;

    typedef struct {int cyc; int val;} bexp_t;
    typedef struct {int m; int ch; int d;} pexp_t;

    bexp_t busy_q[$];
    pexp_t per_q[$];
    logic [15:0] pat [3];
    int tests = 0;
    int fails = 0;
    int k;

`ifdef LED_FADE_BREATHE_EN
    localparam int G1 = 3, G4 = 15, G5 = 11, G8 = 1, G9 = 5, G13 = 9, GB = 0;
`else
    localparam int G1 = 0, G4 = 0, G5 = 0, G8 = 0, G9 = 0, G13 = 0, GB = 1;
`endif

    led_fade_pwm #(.PWM_BITS(4), .STEP_LOG2(2), .MAX_DUTY(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_blue(req_blue), .req_red(req_red), .req_green(req_green),
        .blue_pwm(blue_pwm), .red_pwm(red_pwm), .green_pwm(green_pwm), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) k <= 0;
        else k <= k + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pb(input int cyc, input int val);
        busy_q.push_back('{cyc, val});
    endtask

    task automatic pp(input int m, input int ch, input int d);
        per_q.push_back('{m, ch, d});
    endtask

    task automatic at_cyc(input int j);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (k != j && n < 1000);
        if (k != j) begin
            tests++;
            fails++;
            $display("FAIL wait for cycle %0d: stuck at %0d", j, k);
        end
    endtask

    // monitor: samples outputs after every counting edge and pops due expectations
    initial begin : monitor
        bexp_t be;
        pexp_t pe;
        int m;
        string nm [3];
        nm[0] = "blue"; nm[1] = "red"; nm[2] = "green";
        forever begin
            @(negedge clk);
            if (rst_n && k >= 1) begin
                pat[0][(k-1)%16] = blue_pwm;
                pat[1][(k-1)%16] = red_pwm;
                pat[2][(k-1)%16] = green_pwm;
                while (busy_q.size() > 0 && busy_q[0].cyc <= k) begin
                    be = busy_q.pop_front();
                    if (be.cyc == k) check($sformatf("busy at cycle %0d", k), int'(busy), be.val);
                    else check($sformatf("busy sample %0d missed", be.cyc), k, be.cyc);
                end
                if (k % 16 == 0) begin
                    m = k / 16 - 1;
                    while (per_q.size() > 0 && per_q[0].m <= m) begin
                        pe = per_q.pop_front();
                        if (pe.m == m)
                            check($sformatf("%s period %0d pattern", nm[pe.ch], m),
                                  int'(pat[pe.ch]), (1 << pe.d) - 1);
                        else check($sformatf("%s period %0d missed", nm[pe.ch], pe.m), m, pe.m);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        pb(5, 0);    pb(6, 1);    pb(64, 1);   pb(65, 0);
        pb(69, 0);   pb(70, 1);   pb(124, 1);  pb(125, 0);
        pb(132, 0);  pb(133, 1);  pb(192, 1);  pb(193, 0);
        pb(203, 0);  pb(204, GB); pb(205, GB); pb(206, 0);
        pp(0, 0, 0);   pp(0, 1, 0);  pp(0, 2, 0);
        pp(1, 0, 2);   pp(1, 2, G1);
        pp(2, 0, 6);
        pp(3, 0, 10);
        pp(4, 0, 14);  pp(4, 1, 0);  pp(4, 2, G4);
        pp(5, 0, 15);  pp(5, 1, 2);  pp(5, 2, G5);
        pp(6, 0, 15);  pp(6, 1, 6);
        pp(7, 0, 15);  pp(7, 1, 4);
        pp(8, 0, 15);  pp(8, 1, 0);  pp(8, 2, G8);
        pp(9, 0, 13);  pp(9, 1, 0);  pp(9, 2, G9);
        pp(10, 0, 9);
        pp(11, 0, 5);
        pp(12, 0, 1);
        pp(13, 0, 0);  pp(13, 2, G13);
        pp(15, 0, 1);

        req_blue = 1'b1; req_red = 1'b1; req_green = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1 || i == 10 || i == 20)
                check($sformatf("outputs in reset, clock %0d", i),
                      int'({blue_pwm, red_pwm, green_pwm, busy}), 0);
        end
        req_blue = 1'b0; req_red = 1'b0; req_green = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        at_cyc(3);   req_blue = 1'b1;
        at_cyc(67);  req_red = 1'b1;
        at_cyc(96);  req_red = 1'b0;
        at_cyc(130); req_blue = 1'b0;
        at_cyc(201); req_green = 1'b1;
        at_cyc(202); req_green = 1'b0;
        at_cyc(230); req_blue = 1'b1;
        at_cyc(257);
        check("blue high at period start", int'(blue_pwm), 1);
        check("busy while blue rises again", int'(busy), 1);
        at_cyc(258);
        #2;
        check("blue high before async reset", int'(blue_pwm), 1);
        rst_n = 1'b0;
        #1;
        check("outputs right after async reset", int'({blue_pwm, red_pwm, green_pwm, busy}), 0);
        repeat (3) @(negedge clk);
        check("outputs held in reset", int'({blue_pwm, red_pwm, green_pwm, busy}), 0);
        check("busy expectations left", busy_q.size(), 0);
        check("period expectations left", per_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
